// File: rtl/simon_sched_if.sv
// simon_sched_if: plaintext/ciphertext streams and the round-key RAM port
// of the Simon 128/256 sequencer. "master" is the sequencer side.
interface simon_sched_if #(
  parameter int WORD_BITS = 64,
  parameter int RK_AW     = 7
);
  logic                   pt_valid;
  logic                   pt_ready;
  logic [2*WORD_BITS-1:0] pt_data;
  logic                   ct_valid;
  logic                   ct_ready;
  logic [2*WORD_BITS-1:0] ct_data;
  logic                   rk_wr_en;
  logic [RK_AW-1:0]       rk_wr_addr;
  logic [WORD_BITS-1:0]   rk_wr_data;
  logic                   rk_rd_en;
  logic [RK_AW-1:0]       rk_rd_addr;
  logic [WORD_BITS-1:0]   rk_rd_data;

  modport master (
    input  pt_valid, pt_data, ct_ready, rk_rd_data,
    output pt_ready, ct_valid, ct_data,
    output rk_wr_en, rk_wr_addr, rk_wr_data, rk_rd_en, rk_rd_addr
  );

  modport slave (
    output pt_valid, pt_data, ct_ready, rk_rd_data,
    input  pt_ready, ct_valid, ct_data,
    input  rk_wr_en, rk_wr_addr, rk_wr_data, rk_rd_en, rk_rd_addr
  );
endinterface

// File: rtl/simon_sched.sv
// simon_sched: expands a 256-bit key into ROUNDS round keys written to an
// external RAM, then encrypts plaintext blocks one round per cycle using
// keys read back from that RAM (1-cycle read latency).
module simon_sched #(
  parameter int WORD_BITS = 64,
  parameter int ROUNDS    = 72,
  parameter int RK_AW     = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*WORD_BITS-1:0] init_key,
  input  logic                   key_compute_start,
  output logic                   key_ready,
  output logic                   busy,
  simon_sched_if.master          bus
);
  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_READY, S_ENC, S_DONE} state_t;

  // z4 sequence, index 0 is the leftmost (most significant) bit
  localparam logic [61:0] Z4 =
    62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [RK_AW-1:0]     KEXP_LAST = RK_AW'(ROUNDS - 1);
  localparam logic [RK_AW-1:0]     ENC_LAST  = RK_AW'(ROUNDS);
  localparam logic [WORD_BITS-1:0] C3        = WORD_BITS'(3);

  function automatic logic [WORD_BITS-1:0] rol(input logic [WORD_BITS-1:0] v,
                                               input int unsigned s);
    return (v << s) | (v >> (WORD_BITS - s));
  endfunction

  function automatic logic [WORD_BITS-1:0] ror(input logic [WORD_BITS-1:0] v,
                                               input int unsigned s);
    return (v >> s) | (v << (WORD_BITS - s));
  endfunction

  state_t                    r_state;
  state_t                    w_next;
  logic [RK_AW-1:0]          r_cnt;
  logic [5:0]                r_zidx;
  logic                      r_pend;
  logic                      r_key_ready;
  logic [3:0][WORD_BITS-1:0] r_k;
  logic [WORD_BITS-1:0]      r_x;
  logic [WORD_BITS-1:0]      r_y;

  logic                      w_load_key;
  logic                      w_pt_ready;
  logic                      w_accept;
  logic                      w_start_pend;
  logic                      w_wr_en;
  logic                      w_rd_en;
  logic [61:0]               w_zvec;
  logic [WORD_BITS-1:0]      w_tmp0;
  logic [WORD_BITS-1:0]      w_tmp;
  logic [WORD_BITS-1:0]      w_k_new;
  logic [WORD_BITS-1:0]      w_x_new;

  // a re-key request is honoured if it is pending or arrives this very cycle
  assign w_start_pend = r_pend | key_compute_start;
  assign w_accept     = w_pt_ready & bus.pt_valid;

  // next key word and next round x value
  always_comb begin
    w_zvec  = Z4 << r_zidx;
    w_tmp0  = ror(r_k[3], 3) ^ r_k[1];
    w_tmp   = w_tmp0 ^ ror(w_tmp0, 1);
    w_k_new = ~r_k[0] ^ w_tmp ^ C3 ^ {{(WORD_BITS-1){1'b0}}, w_zvec[61]};
    w_x_new = r_y ^ (rol(r_x, 1) & rol(r_x, 8)) ^ rol(r_x, 2) ^ bus.rk_rd_data;
  end

  // next-state decode; w_load_key marks every entry into key expansion
  always_comb begin
    w_next     = r_state;
    w_load_key = 1'b0;
    w_pt_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (key_compute_start) begin
          w_next     = S_KEXP;
          w_load_key = 1'b1;
        end
      end
      S_KEXP: begin
        if (r_cnt == KEXP_LAST) begin
          if (w_start_pend) begin
            w_next     = S_KEXP;
            w_load_key = 1'b1;
          end else begin
            w_next = S_READY;
          end
        end
      end
      S_READY: begin
        if (key_compute_start) begin
          w_next     = S_KEXP;
          w_load_key = 1'b1;
        end else begin
          w_pt_ready = ~r_pend;
          if (bus.pt_valid && !r_pend) w_next = S_ENC;
        end
      end
      S_ENC: begin
        if (r_cnt == ENC_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.ct_ready) begin
          if (w_start_pend) begin
            w_next     = S_KEXP;
            w_load_key = 1'b1;
          end else begin
            w_next = S_READY;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // control state: FSM, counters, pending re-key flag, key_ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_zidx      <= '0;
      r_pend      <= 1'b0;
      r_key_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load_key) begin
        r_cnt       <= '0;
        r_zidx      <= '0;
        r_pend      <= 1'b0;
        r_key_ready <= 1'b0;
      end else begin
        if (key_compute_start &&
            (r_state == S_KEXP || r_state == S_ENC || r_state == S_DONE))
          r_pend <= 1'b1;
        case (r_state)
          S_KEXP: begin
            r_zidx <= (r_zidx == 6'd61) ? 6'd0 : r_zidx + 6'd1;
            if (r_cnt == KEXP_LAST) begin
              r_cnt       <= '0;
              r_key_ready <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_READY: if (w_accept) r_cnt <= '0;
          S_ENC:   r_cnt <= (r_cnt == ENC_LAST) ? '0 : r_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // datapath: key shift register and x/y round state (no reset needed)
  always_ff @(posedge clk) begin
    if (w_load_key)
      r_k <= init_key;
    else if (r_state == S_KEXP)
      r_k <= {w_k_new, r_k[3:1]};
    // round j uses the key read in round j-1, so round 0 only issues a read
    if (w_accept) begin
      {r_x, r_y} <= bus.pt_data;
    end else if (r_state == S_ENC && r_cnt != '0) begin
      r_x <= w_x_new;
      r_y <= r_x;
    end
  end

  assign w_wr_en = (r_state == S_KEXP);
  assign w_rd_en = (r_state == S_ENC) && (r_cnt != ENC_LAST);

  assign bus.rk_wr_en   = w_wr_en;
  assign bus.rk_wr_addr = w_wr_en ? r_cnt : '0;
  assign bus.rk_wr_data = w_wr_en ? r_k[0] : '0;
  assign bus.rk_rd_en   = w_rd_en;
  assign bus.rk_rd_addr = w_rd_en ? r_cnt : '0;
  assign bus.pt_ready   = w_pt_ready;
  assign bus.ct_valid   = (r_state == S_DONE);
  assign bus.ct_data    = (r_state == S_DONE) ? {r_x, r_y} : '0;
  assign key_ready      = r_key_ready;
  assign busy           = (r_state == S_KEXP) || (r_state == S_ENC) ||
                          (r_state == S_DONE);
endmodule
